// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC fetch unit.
//   fetch_state_e   : top-level fetch state (RUN, HALTED, ERROR)
//   NOP_INSTR       : default bubble instruction (addi x0,x0,0)
//   is_legal_target : redirect target check (word alignment + fits in PC_W bits)
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Legal when word aligned and every bit at or above pc_w is zero.
    function automatic logic is_legal_target(input logic [31:0] br_pc,
                                             input int unsigned pc_w);
        logic [31:0] high_mask;
        high_mask = 32'hFFFF_FFFF << pc_w;
        return (br_pc[1:0] == 2'b00) && ((br_pc & high_mask) == 32'h0);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold and flush.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   en             : load pc/instr and mark the entry valid
//   flush          : load a bubble (pc=0, NOP, valid=0); wins over en
//   pc, instr      : incoming fetch PC (zero-extended) and instruction word
//   q_pc, q_instr  : registered PC and instruction
//   q_valid        : registered valid bit
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] q_pc,
    output logic [31:0] q_instr,
    output logic        q_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_pc    <= 32'h0;
            q_instr <= NOP_INSTR;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_pc    <= 32'h0;
            q_instr <= NOP_INSTR;
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= pc;
            q_instr <= instr;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: owns the PC, addresses instruction memory and loads IF/ID.
// Handles taken-branch redirects (with wrong-path squash), halt, stall and
// traps on illegal redirect targets.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   stall        : hold PC and IF/ID
//   pc_sel       : redirect request, target on br_pc
//   br_pc        : redirect target
//   halt         : halt request
//   inst_rdata   : instruction memory read data for inst_addr
//   inst_addr    : current PC
//   if_id_pc     : PC of the IF/ID instruction, zero-extended
//   if_id_instr  : IF/ID instruction
//   if_id_valid  : IF/ID holds a real instruction
//   flush_id_ex  : one-cycle pulse after a redirect edge
//   halted       : HALTED or ERROR
//   trap         : ERROR (sticky until reset)
//   fetch_count  : valid instructions loaded into IF/ID
module pc_fetch_unit #(
    parameter int unsigned       PC_W      = 9,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = pc_fetch_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      br_pc,
    input  logic             halt,
    input  logic [31:0]      inst_rdata,
    output logic [PC_W-1:0]  inst_addr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             trap,
    output logic [31:0]      fetch_count
);

    import pc_fetch_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic            flush_q, flush_d;
    logic            ifid_en;
    logic            ifid_flush;
    logic            target_ok;

    assign target_ok = is_legal_target(br_pc, PC_W);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        flush_d    = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (pc_sel) begin
                    // Redirect beats halt and stall; the wrong-path fetch is squashed.
                    ifid_flush = 1'b1;
                    flush_d    = 1'b1;
                    if (target_ok) begin
                        pc_d = br_pc[PC_W-1:0];
                    end else begin
                        state_d = ERROR;
                    end
                end else if (halt) begin
                    state_d    = HALTED;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_W'(4);
                    ifid_en = 1'b1;
                    count_d = count_q + 32'd1;
                end
            end
            default: begin
                // HALTED / ERROR: everything frozen until reset.
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= 32'h0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            flush_q <= flush_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (ifid_en),
        .flush   (ifid_flush),
        .pc      (32'(pc_q)),
        .instr   (inst_rdata),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

    assign inst_addr   = pc_q;
    assign flush_id_ex = flush_q;
    assign halted      = (state_q != RUN);
    assign trap        = (state_q == ERROR);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_sel;
    logic [31:0] br_pc;
    logic        halt;
    logic [31:0] inst_rdata;
    logic [8:0]  inst_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        flush_id_ex;
    logic        halted;
    logic        trap;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [8:0]  addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        logic        hlt;
        logic        trp;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .br_pc       (br_pc),
        .halt        (halt),
        .inst_rdata  (inst_rdata),
        .inst_addr   (inst_addr),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .flush_id_ex (flush_id_ex),
        .halted      (halted),
        .trap        (trap),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at byte address a holds 0xA0 + a/4.
    assign inst_rdata = 32'hA0 + 32'(inst_addr >> 2);

    task automatic chk(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got=%h expected=%h", name, field, got, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk(e.name, "inst_addr",   32'(inst_addr),   32'(e.addr));
        chk(e.name, "if_id_pc",    if_id_pc,         e.pc);
        chk(e.name, "if_id_instr", if_id_instr,      e.instr);
        chk(e.name, "if_id_valid", 32'(if_id_valid), 32'(e.valid));
        chk(e.name, "flush_id_ex", 32'(flush_id_ex), 32'(e.flush));
        chk(e.name, "halted",      32'(halted),      32'(e.hlt));
        chk(e.name, "trap",        32'(trap),        32'(e.trp));
        chk(e.name, "fetch_count", fetch_count,      e.cnt);
    endtask

    // Monitor: compares the DUT state after each edge against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk_all(e);
        end
    end

    function automatic exp_t mk(input string name, input logic [8:0] addr,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic valid, input logic flush,
                                input logic hlt, input logic trp,
                                input logic [31:0] cnt);
        exp_t e;
        e.name  = name;
        e.addr  = addr;
        e.pc    = pc;
        e.instr = instr;
        e.valid = valid;
        e.flush = flush;
        e.hlt   = hlt;
        e.trp   = trp;
        e.cnt   = cnt;
        return e;
    endfunction

    // Apply inputs for one edge and queue the state expected after it.
    task automatic cyc(input logic s, input logic ps, input logic [31:0] br,
                       input logic h, input exp_t e);
        stall  = s;
        pc_sel = ps;
        br_pc  = br;
        halt   = h;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    // Reset asserted mid-cycle; outputs must take reset values at once.
    task automatic do_reset(input string name);
        @(negedge clk);
        #1;
        stall  = 1'b0;
        pc_sel = 1'b0;
        br_pc  = 32'h0;
        halt   = 1'b0;
        reset  = 1'b1;
        #1;
        chk_all(mk({name, "_async"}, 9'h000, 32'h0, 32'h13, 0, 0, 0, 0, 32'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back(mk({name, "_post"}, 9'h000, 32'h0, 32'h13, 0, 0, 0, 0, 32'd0));
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        reset  = 1'b0;
        stall  = 1'b0;
        pc_sel = 1'b0;
        br_pc  = 32'h0;
        halt   = 1'b0;

        do_reset("rst0");

        // Straight-line fetch
        cyc(0, 0, 0, 0, mk("seq0", 9'h004, 32'h000, 32'hA0, 1, 0, 0, 0, 1));
        cyc(0, 0, 0, 0, mk("seq1", 9'h008, 32'h004, 32'hA1, 1, 0, 0, 0, 2));
        cyc(0, 0, 0, 0, mk("seq2", 9'h00C, 32'h008, 32'hA2, 1, 0, 0, 0, 3));
        cyc(0, 0, 0, 0, mk("seq3", 9'h010, 32'h00C, 32'hA3, 1, 0, 0, 0, 4));
        // Redirect at PC=0x010 to 0x040
        cyc(0, 1, 32'h40, 0, mk("br40", 9'h040, 32'h0, NOP, 0, 1, 0, 0, 4));
        cyc(0, 0, 0, 0, mk("br40_n", 9'h044, 32'h040, 32'hB0, 1, 0, 0, 0, 5));
        // Move to 0x020, stall twice, then redirect while stalled
        cyc(0, 1, 32'h20, 0, mk("br20", 9'h020, 32'h0, NOP, 0, 1, 0, 0, 5));
        cyc(1, 0, 0, 0, mk("stall0", 9'h020, 32'h0, NOP, 0, 0, 0, 0, 5));
        cyc(1, 0, 0, 0, mk("stall1", 9'h020, 32'h0, NOP, 0, 0, 0, 0, 5));
        cyc(1, 1, 32'h80, 0, mk("stall_br", 9'h080, 32'h0, NOP, 0, 1, 0, 0, 5));
        cyc(0, 0, 0, 0, mk("br80_n", 9'h084, 32'h080, 32'hC0, 1, 0, 0, 0, 6));
        // PC wrap 0x1FC -> 0x000
        cyc(0, 1, 32'h1FC, 0, mk("br1fc", 9'h1FC, 32'h0, NOP, 0, 1, 0, 0, 6));
        cyc(0, 0, 0, 0, mk("wrap", 9'h000, 32'h1FC, 32'h11F, 1, 0, 0, 0, 7));
        cyc(0, 0, 0, 0, mk("wrap_n", 9'h004, 32'h000, 32'hA0, 1, 0, 0, 0, 8));
        // Redirect and halt together: redirect wins, halt next edge
        cyc(0, 1, 32'h30, 1, mk("br_halt", 9'h030, 32'h0, NOP, 0, 1, 0, 0, 8));
        cyc(0, 0, 0, 1, mk("halt", 9'h030, 32'h0, NOP, 0, 0, 1, 0, 8));
        cyc(0, 1, 32'h40, 0, mk("halt_ign", 9'h030, 32'h0, NOP, 0, 0, 1, 0, 8));
        cyc(0, 0, 0, 0, mk("halt_hold", 9'h030, 32'h0, NOP, 0, 0, 1, 0, 8));

        // Misaligned target traps
        do_reset("rst1");
        cyc(0, 0, 0, 0, mk("t0", 9'h004, 32'h000, 32'hA0, 1, 0, 0, 0, 1));
        cyc(0, 1, 32'h42, 0, mk("mis", 9'h004, 32'h0, NOP, 0, 1, 1, 1, 1));
        cyc(0, 1, 32'h40, 0, mk("err_ign", 9'h004, 32'h0, NOP, 0, 0, 1, 1, 1));
        cyc(0, 0, 0, 1, mk("err_hold", 9'h004, 32'h0, NOP, 0, 0, 1, 1, 1));

        // Out-of-range target traps
        do_reset("rst2");
        cyc(0, 1, 32'h200, 0, mk("oor", 9'h000, 32'h0, NOP, 0, 1, 1, 1, 0));
        cyc(0, 0, 0, 0, mk("oor_hold", 9'h000, 32'h0, NOP, 0, 0, 1, 1, 0));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got=%0d pending expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Consumer end of the branch-redirect interface. It owns the PC register, drives the instruction-memory address and loads the IF/ID pipeline register. On a taken-branch redirect (pc_sel/br_pc) it reloads the PC and squashes the wrong-path fetch. It also handles halt and stall, and traps on illegal redirect targets.

Parameters:
PC_W, 9, PC/instruction-memory byte-address width.
RESET_PC, 0, PC value loaded on reset (PC_W bits, word aligned).
NOP_INSTR, 32'h00000013, bubble instruction written to IF/ID on squash (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hazard-unit stall; hold PC and IF/ID.
pc_sel  in  1  1 = branch/jump taken this cycle (EX stage).
br_pc  in  32  redirect target, valid when pc_sel=1.
halt  in  1  non-speculative halt request.
inst_rdata  in  32  instruction-memory read data for inst_addr (combinational read).
inst_addr  out  PC_W  current PC to instruction memory.
if_id_pc  out  32  PC of the instruction in IF/ID, zero-extended.
if_id_instr  out  32  instruction in IF/ID.
if_id_valid  out  1  1 = IF/ID holds a real instruction.
flush_id_ex  out  1  one-cycle pulse: downstream must bubble ID/EX.
halted  out  1  1 in HALTED or ERROR state.
trap  out  1  sticky; 1 in ERROR state.
fetch_count  out  32  number of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset (async, any cycle): PC=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, flush_id_ex=0, halted=0, trap=0, fetch_count=0, state=RUN.
- inst_addr = PC (combinational from the register). Fetch latency is one cycle: instruction at PC appears in IF/ID after the next rising edge.
- States: RUN, HALTED, ERROR. HALTED and ERROR are left only by reset.
- RUN priority per edge is redirect > halt > stall > normal.
- Redirect (pc_sel=1):
  - Legal target (br_pc[1:0]==0 and br_pc[31:PC_W]==0): PC<=br_pc[PC_W-1:0]; IF/ID<=NOP_INSTR with valid=0 and if_id_pc=0; flush_id_ex=1 for exactly that next cycle; fetch_count unchanged.
  - Stall is overridden by a redirect.
  - Illegal target: go to ERROR. PC holds. IF/ID gets a bubble. flush_id_ex pulses once. trap=1.
- Halt (halt=1, pc_sel=0): go to HALTED. PC holds. IF/ID gets a bubble (valid=0). No flush pulse. halted=1 from the next cycle.
- Stall (stall=1, pc_sel=0, halt=0): PC, IF/ID and fetch_count all hold.
- Normal: PC<=PC+4, wrapping mod 2^PC_W (e.g. 0x1FC->0x000 for PC_W=9); IF/ID<={zero-extended PC, inst_rdata}, valid=1; fetch_count+=1, wrapping mod 2^32.
- HALTED/ERROR: all registers hold except the flush pulse, which drops to 0; pc_sel, halt and stall are ignored.
- flush_id_ex is registered and is 0 in every cycle not directly following a redirect edge.
- Simultaneous pc_sel & halt: the redirect is taken and halt is ignored that cycle. If halt remains asserted, the unit halts on the next edge.

Decomposition:
- Shared package pc_fetch_pkg: state enum fetch_state_e {RUN, HALTED, ERROR}, constant NOP_INSTR, function is_legal_target(br_pc) (alignment plus range check).
- One natural sub-module, if_id_reg: a holdable/flushable pipeline register with inputs pc, instr, en, flush.
- Next-PC and FSM logic stay in the top module.

Test Plan:
- Reset then 3 normal cycles, memory returns 0xA0,0xA1,0xA2 -> IF/ID pc sequence 0,4,8 with those instrs; valid=1; fetch_count=3; inst_addr=0x00C.
- At PC=0x010, pc_sel=1, br_pc=0x40 -> next cycle inst_addr=0x040, if_id_instr=0x00000013, valid=0, flush_id_ex=1 for one cycle; following cycle if_id_pc=0x40, valid=1.
- stall=1 for 2 cycles at PC=0x020, then pc_sel=1, br_pc=0x80 while still stalled -> PC holds 0x020 for 2 cycles, then jumps to 0x080 (redirect beats stall).
- PC=0x1FC normal step -> inst_addr=0x000; separately br_pc=0x42 or br_pc=0x200 -> trap=1, halted=1, PC unchanged, further pc_sel ignored.
- pc_sel=1 and halt=1 in the same cycle with br_pc=0x30 -> PC=0x030, halted=0. Holding halt -> halted=1 next cycle, PC frozen at 0x030. Async reset asserted mid-cycle -> all outputs at reset values immediately.
